sgbus_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single Aurora sgbus TX stream among NumSrc AXI-Stream sources, e.g. the AXI map response path, a status reporter and a debug injector. Sits between the sources and the scaled Aurora core TX port in the aurora_userclk domain. Once a source is granted, it keeps the stream until its tlast beat. A half-full backpressure flag from the core holds off new grants only; it never breaks a packet in progress.

---
 rtl/sgbus_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_sgbus_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgbus_tx_arbiter.sv
// rtl/sgbus_tx_arbiter.sv - packet-atomic round-robin arbiter onto the sgbus TX stream (optional SGBUS_ARB_STATS_EN)
//
// Stream lanes are flattened into plain vectors. Per-source request layout (ReqWidth bits):
//   [0]                          tvalid
//   [1]                          t.last
//   [2 +: KeepWidth]             t.keep
//   [2+KeepWidth +: DataWidth]   t.data
// Source i occupies s_axis_req[i*ReqWidth +: ReqWidth]; s_axis_resp[i] is its tready.
// m_axis_resp is the core's tready.
// Define SGBUS_ARB_STATS_EN to add the per-source pkt_cnt counters (CntWidth each, packed like the requests).

module sgbus_tx_arbiter #(
    parameter int NumSrc    = 3,
    parameter int DataWidth = 32,
    parameter int KeepWidth = DataWidth / 8,
    parameter int ReqWidth  = DataWidth + KeepWidth + 2,
    parameter int IdxWidth  = $clog2(NumSrc),
    parameter int CntWidth  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NumSrc*ReqWidth-1:0]   s_axis_req,
    output logic [NumSrc-1:0]            s_axis_resp,
    output logic [ReqWidth-1:0]          m_axis_req,
    input  logic                         m_axis_resp,
    input  logic                         tx_hf,
    output logic                         busy,
    output logic [IdxWidth-1:0]          grant_idx
`ifdef SGBUS_ARB_STATS_EN
    ,
    output logic [NumSrc*CntWidth-1:0]   pkt_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IdxWidth-1:0]   rr_ptr;
    logic [IdxWidth-1:0]   rr_ptr_nxt;
    logic [IdxWidth-1:0]   grant_nxt;

    logic [ReqWidth-1:0]   src_req [NumSrc];
    logic [NumSrc-1:0]     src_valid;
    logic [ReqWidth-1:0]   sel_req;

    logic                  pick_found;
    logic [IdxWidth-1:0]   pick_idx;
    logic [IdxWidth-1:0]   cand_idx;
    logic                  pkt_done;

    // Split the flattened source bus into one request word per source.
    for (genvar g = 0; g < NumSrc; g++) begin : g_unpack
        assign src_req[g]   = s_axis_req[g*ReqWidth +: ReqWidth];
        assign src_valid[g] = src_req[g][0];
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping modulo NumSrc.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NumSrc; i++) begin
            cand_idx = IdxWidth'((int'(rr_ptr) + i) % NumSrc);
            if (!pick_found && src_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state and output decode; the granted source owns the stream until its tlast handshake.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        grant_nxt   = grant_idx;
        sel_req     = src_req[grant_idx];
        m_axis_req  = '0;
        s_axis_resp = '0;
        busy        = 1'b0;
        pkt_done    = 1'b0;
        case (state)
            IDLE: begin
                // tx_hf only gates new grants, so it is looked at here and nowhere else.
                if (!tx_hf && pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                busy                   = 1'b1;
                m_axis_req             = sel_req;
                s_axis_resp[grant_idx] = m_axis_resp;
                if (sel_req[0] && sel_req[1] && m_axis_resp) begin
                    pkt_done   = 1'b1;
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_idx == IdxWidth'(NumSrc - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_idx <= grant_nxt;
        end
    end

`ifdef SGBUS_ARB_STATS_EN
    for (genvar g = 0; g < NumSrc; g++) begin : g_stats
        logic [CntWidth-1:0] cnt;

        // Count completed packets of this source; wraps naturally, cleared only by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (pkt_done && (grant_idx == IdxWidth'(g))) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign pkt_cnt[g*CntWidth +: CntWidth] = cnt;
    end
`endif

endmodule

// File: tb/tb_sgbus_tx_arbiter.sv
// tb/tb_sgbus_tx_arbiter.sv - directed and randomized bench for sgbus_tx_arbiter against a packet-level model

module tb_sgbus_tx_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int RW = DW + KW + 2;
    localparam int IW = 2;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*RW-1:0]   s_axis_req;
    logic [N-1:0]      s_axis_resp;
    logic [RW-1:0]     m_axis_req;
    logic              m_axis_resp;
    logic              tx_hf;
    logic              busy;
    logic [IW-1:0]     grant_idx;
`ifdef SGBUS_ARB_STATS_EN
    logic [N*CW-1:0]   pkt_cnt;
`endif

    always #5 clk = ~clk;

    sgbus_tx_arbiter #(
        .NumSrc    (N),
        .DataWidth (DW),
        .CntWidth  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis_req  (s_axis_req),
        .s_axis_resp (s_axis_resp),
        .m_axis_req  (m_axis_req),
        .m_axis_resp (m_axis_resp),
        .tx_hf       (tx_hf),
        .busy        (busy),
        .grant_idx   (grant_idx)
`ifdef SGBUS_ARB_STATS_EN
        ,
        .pkt_cnt     (pkt_cnt)
`endif
    );

    // Reference model: per-source beat queues {data, keep, last}, current owner (-1 = none),
    // round-robin start point, completed-packet log and per-source packet counts.
    logic [DW+KW:0] q [N][$];
    logic [N-1:0]   pres;
    int             owner;
    int             rr;
    int             last_grant;
    int             cnt [N];
    int             done_src [$];
    int             gap_pct;
    bit             rand_mode;
    int             n_checks;
    int             n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        for (int b = 0; b < len; b++)
            q[s].push_back({32'($urandom()), 4'($urandom()), 1'(b == len - 1)});
    endtask

    function automatic bit all_empty();
        for (int s = 0; s < N; s++)
            if (q[s].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive sources, check outputs against the model, advance the model, wait for next negedge.
    task automatic cycle();
        logic [N*RW-1:0] drv;
        logic [N-1:0]    exp_r;
        logic [DW+KW:0]  beat;
        for (int s = 0; s < N; s++)
            if (!pres[s] && q[s].size() > 0 && $urandom_range(99) >= gap_pct) pres[s] = 1'b1;
        drv = '0;
        for (int s = 0; s < N; s++)
            if (pres[s]) drv[s*RW +: RW] = {q[s][0], 1'b1};
        s_axis_req = drv;
        if (rand_mode) begin
            m_axis_resp = ($urandom_range(99) < 70);
            tx_hf       = ($urandom_range(99) < 20);
        end
        #1;
        if (owner < 0) begin
            check("busy_idle", busy, 0);
            check("m_tvalid_idle", m_axis_req[0], 0);
            check("s_tready_idle", s_axis_resp, 0);
        end else begin
            check("busy_lock", busy, 1);
            check("m_req", m_axis_req, drv[owner*RW +: RW]);
            exp_r = '0;
            exp_r[owner] = m_axis_resp;
            check("s_tready", s_axis_resp, exp_r);
        end
        check("grant_idx", grant_idx, last_grant);
`ifdef SGBUS_ARB_STATS_EN
        for (int s = 0; s < N; s++) check("pkt_cnt", pkt_cnt[s*CW +: CW], cnt[s]);
`endif
        if (owner < 0) begin
            if (!tx_hf) begin
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (rr + i) % N;
                    if (owner < 0 && pres[c]) begin
                        owner      = c;
                        last_grant = c;
                    end
                end
            end
        end else if (pres[owner] && m_axis_resp) begin
            beat = q[owner].pop_front();
            pres[owner] = 1'b0;
            if (beat[0]) begin
                cnt[owner]++;
                done_src.push_back(owner);
                rr    = (owner + 1) % N;
                owner = -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input string tag, input int bound, output int n);
        n = 0;
        while ((owner >= 0 || !all_empty()) && n < bound) begin
            cycle();
            n++;
        end
        check({tag, "_bound"}, (n < bound), 1);
    endtask

    task automatic apply_reset();
        logic [DW+KW:0] beat;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_m_tvalid", m_axis_req[0], 0);
        check("rst_s_tready", s_axis_resp, 0);
        check("rst_grant", grant_idx, 0);
`ifdef SGBUS_ARB_STATS_EN
        check("rst_pkt_cnt", pkt_cnt, 0);
`endif
        if (owner >= 0) begin
            while (q[owner].size() > 0) begin
                beat = q[owner].pop_front();
                if (beat[0]) break;
            end
            pres[owner] = 1'b0;
        end
        owner      = -1;
        rr         = 0;
        last_grant = 0;
        for (int s = 0; s < N; s++) cnt[s] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [DW+KW:0] beat2;
        n_checks    = 0;
        n_fail      = 0;
        owner       = -1;
        rr          = 0;
        last_grant  = 0;
        pres        = '0;
        gap_pct     = 0;
        rand_mode   = 1'b0;
        rst_n       = 1'b0;
        s_axis_req  = '0;
        m_axis_resp = 1'b1;
        tx_hf       = 1'b0;
        for (int s = 0; s < N; s++) cnt[s] = 0;
        apply_reset();

        // Single 4-beat packet from source 1: one idle cycle plus four beats, then rr_ptr=2.
        add_pkt(1, 4);
        run_until_idle("t1", 50, n);
        check("t1_cycles", n, 5);
        check("t1_src", done_src[done_src.size()-1], 1);
        add_pkt(0, 1);
        add_pkt(2, 1);
        cycle();
        check("t1_rr_grant", grant_idx, 2);
        run_until_idle("t1b", 50, n);

        // All three sources with two 2-beat packets each: order 0,1,2,0,1,2 in 18 cycles.
        apply_reset();
        done_src.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add_pkt(s, 2);
        run_until_idle("t2", 100, n);
        check("t2_cycles", n, 18);
        check("t2_count", done_src.size(), 6);
        for (int i = 0; i < done_src.size(); i++) check("t2_order", done_src[i], i % N);

        // tx_hf rises on beat 2 of 5: packet completes, pending source 2 waits for tx_hf=0.
        done_src.delete();
        add_pkt(0, 5);
        add_pkt(2, 2);
        run(2);
        tx_hf = 1'b1;
        run(4);
        check("t3_src0_done", done_src.size(), 1);
        run(3);
        check("t3_held_busy", busy, 0);
        tx_hf = 1'b0;
        run_until_idle("t3", 50, n);
        check("t3_src2_done", done_src[done_src.size()-1], 2);

        // Core tready 1,0,0,1 during a 3-beat packet: data held, only the granted source sees tready.
        done_src.delete();
        add_pkt(1, 3);
        add_pkt(2, 1);
        beat2 = q[1][1];
        m_axis_resp = 1'b1;
        cycle();
        cycle();
        m_axis_resp = 1'b0;
        cycle();
        cycle();
        check("t4_stall_data", m_axis_req, {beat2, 1'b1});
        check("t4_stall_ready", s_axis_resp, 0);
        m_axis_resp = 1'b1;
        run_until_idle("t4", 50, n);
        check("t4_first", done_src[0], 1);

        // Reset mid-packet, then the lowest-index requester wins.
        add_pkt(2, 4);
        run(3);
        check("t5_busy_pre", busy, 1);
        apply_reset();
        done_src.delete();
        add_pkt(1, 1);
        add_pkt(2, 1);
        cycle();
        check("t5_grant", grant_idx, 1);
        run_until_idle("t5", 50, n);
        check("t5_first", done_src[0], 1);

        // Statistics: 5 packets from source 1 and 2 from source 0.
        apply_reset();
        for (int i = 0; i < 5; i++) add_pkt(1, $urandom_range(1, 3));
        for (int i = 0; i < 2; i++) add_pkt(0, $urandom_range(1, 3));
        run_until_idle("t6", 200, n);
`ifdef SGBUS_ARB_STATS_EN
        check("t6_cnt0", pkt_cnt[0*CW +: CW], 2);
        check("t6_cnt1", pkt_cnt[1*CW +: CW], 5);
        check("t6_cnt2", pkt_cnt[2*CW +: CW], 0);
`endif

        // Randomized traffic with source gaps, core backpressure and tx_hf.
        rand_mode = 1'b1;
        gap_pct   = 30;
        for (int i = 0; i < 400; i++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 6));
        run_until_idle("rand", 30000, n);
        rand_mode   = 1'b0;
        gap_pct     = 0;
        tx_hf       = 1'b0;
        m_axis_resp = 1'b1;
        run_until_idle("drain", 500, n);
        check("rand_drained", all_empty(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
